div113_seq_ctrl: RTL and testbench



---
 rtl/div_const_pkg.sv | 17 +
 rtl/div113_seq_ctrl_if.sv | 26 ++
 rtl/div113_step.sv | 30 +++
 rtl/div113_seq_ctrl.sv | 90 +++++++++
 tb/tb_div113_seq_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/div_const_pkg.sv
// Shared constants, derived sizes and FSM state type for the constant-divider datapath.
package div_const_pkg;

   localparam int unsigned DW      = 60;
   localparam int unsigned DIVISOR = 113;
   localparam int unsigned RW      = 7;
   localparam int unsigned CHUNK   = 6;
   localparam int unsigned NDIGITS = DW / CHUNK;
   localparam int unsigned CNTW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div113_seq_ctrl_if.sv
// Valid/ready dividend-in / quotient-out bundle for the sequential constant divider.
interface div113_seq_ctrl_if #(
   parameter int unsigned DW = div_const_pkg::DW,
   parameter int unsigned RW = div_const_pkg::RW
);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_dividend;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_quotient;
   logic [RW-1:0] out_remainder;
   logic          busy;

   modport master (
      output in_valid, in_dividend, out_ready,
      input  in_ready, out_valid, out_quotient, out_remainder, busy
   );

   modport slave (
      input  in_valid, in_dividend, out_ready,
      output in_ready, out_valid, out_quotient, out_remainder, busy
   );

endinterface

// File: rtl/div113_step.sv
// One radix-2^CHUNK long-division step: (rem, chunk) -> (digit, rem_next). Purely combinational.
module div113_step #(
   parameter int unsigned RW      = div_const_pkg::RW,
   parameter int unsigned CHUNK   = div_const_pkg::CHUNK,
   parameter int unsigned DIVISOR = div_const_pkg::DIVISOR
) (
   input  logic [RW-1:0]    rem,
   input  logic [CHUNK-1:0] chunk,
   output logic [CHUNK-1:0] digit,
   output logic [RW-1:0]    rem_next
);

   localparam int unsigned     VW    = RW + CHUNK;
   localparam logic [VW-1:0]   DIV_V = VW'(DIVISOR);

   logic [VW-1:0] v;
   logic [VW-1:0] q;
   logic [VW-1:0] r;

   assign v        = {rem, chunk};
   assign q        = v / DIV_V;
   assign r        = v % DIV_V;
   // rem < DIVISOR keeps q below 2^CHUNK, so the upper bits are always zero
   assign digit    = q[CHUNK-1:0];
   assign rem_next = r[RW-1:0];

   logic unused_hi;
   assign unused_hi = ^{q[VW-1:CHUNK], r[VW-1:RW]};

endmodule

// File: rtl/div113_seq_ctrl.sv
// Sequencer that time-shares div113_step over all dividend digits, MSB digit first.
module div113_seq_ctrl
   import div_const_pkg::*;
#(
   parameter int unsigned DW      = div_const_pkg::DW,
   parameter int unsigned DIVISOR = div_const_pkg::DIVISOR,
   parameter int unsigned RW      = div_const_pkg::RW,
   parameter int unsigned CHUNK   = div_const_pkg::CHUNK
) (
   input logic               clk,
   input logic               rst_n,
   div113_seq_ctrl_if.slave  bus
);

   localparam int unsigned    NSTEP = DW / CHUNK;
   localparam int unsigned    CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CW-1:0]  LAST  = CW'(NSTEP - 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]  div_q, div_d;
   logic [DW-1:0]  quo_q, quo_d;
   logic [RW-1:0]  rem_q, rem_d;
   logic [CHUNK-1:0] digit;
   logic [RW-1:0]  rem_step;

   div113_step #(
      .RW      (RW),
      .CHUNK   (CHUNK),
      .DIVISOR (DIVISOR)
   ) u_step (
      .rem      (rem_q),
      .chunk    (div_q[DW-1 -: CHUNK]),
      .digit    (digit),
      .rem_next (rem_step)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               div_d   = bus.in_dividend;
               rem_d   = '0;
               cnt_d   = LAST;
               state_d = BUSY;
            end
         end
         BUSY: begin
            quo_d = (quo_q << CHUNK) | DW'(digit);
            div_d = div_q << CHUNK;
            rem_d = rem_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   // All outputs decode straight from registers; nothing combinational from inputs.
   assign bus.in_ready      = (state_q == IDLE);
   assign bus.busy          = (state_q == BUSY);
   assign bus.out_valid     = (state_q == DONE);
   assign bus.out_quotient  = quo_q;
   assign bus.out_remainder = rem_q;

endmodule

// File: tb/tb_div113_seq_ctrl.sv
// Directed and randomised checks of div113_seq_ctrl against hand-computed and modelled results.
module tb_div113_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   div113_seq_ctrl_if bus ();

   div113_seq_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Offer d once in_ready is seen; returns at the negedge just after the acceptance edge.
   task automatic send(input logic [59:0] d);
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.in_valid    = 1'b1;
      bus.in_dividend = d;
      @(negedge clk);
      bus.in_valid    = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: out_valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
      end
      checks++;
      if (bus.out_quotient !== 60'd0 || bus.out_remainder !== 7'd0) begin
         failures++;
         $display("FAIL reset_data: q=%0d r=%0d required 0 0", bus.out_quotient, bus.out_remainder);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [59:0] dv [5] = '{60'd0, 60'd113, 60'd112, 60'd12345, 60'hFFFFFFFFFFFFFFF};
      logic [59:0] qv [5] = '{60'd0, 60'd1, 60'd0, 60'd109, 60'd10202845173511920};
      logic [6:0]  rv [5] = '{7'd0, 7'd0, 7'd112, 7'd28, 7'd15};
      int lat;
      for (int i = 0; i < 5; i++) begin
         send(dv[i]);
         wait_valid(lat);
         checks++;
         if (lat != 10) begin
            failures++;
            $display("FAIL vec%0d_latency: got %0d cycles required 10", i, lat);
         end
         checks++;
         if (bus.out_quotient !== qv[i] || bus.out_remainder !== rv[i]) begin
            failures++;
            $display("FAIL vec%0d_result: q=%0d r=%0d required q=%0d r=%0d", i,
                     bus.out_quotient, bus.out_remainder, qv[i], rv[i]);
         end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      send(60'd12345);
      wait_valid(lat);
      checks++;
      if (lat != 10) begin
         failures++;
         $display("FAIL bp_latency: got %0d required 10", lat);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_quotient !== 60'd109 ||
             bus.out_remainder !== 7'd28) begin
            failures++;
            $display("FAIL bp_hold%0d: valid=%b in_ready=%b q=%0d r=%0d required 1 0 109 28", i,
                     bus.out_valid, bus.in_ready, bus.out_quotient, bus.out_remainder);
         end
         bus.in_valid    = 1'b1;
         bus.in_dividend = 60'd113;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      handshake();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: valid=%b in_ready=%b busy=%b required 0 1 0",
                  bus.out_valid, bus.in_ready, bus.busy);
      end
      checks++;
      if (bus.out_quotient !== 60'd109 || bus.out_remainder !== 7'd28) begin
         failures++;
         $display("FAIL bp_keep: q=%0d r=%0d required 109 28", bus.out_quotient,
                  bus.out_remainder);
      end
   endtask

   task automatic test_reset_midbusy();
      int lat;
      send(60'hFFFFFFFFFFFFFFF);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_busy: got %b required 1", bus.busy);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_async: busy=%b valid=%b required 0 0", bus.busy, bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_release: in_ready=%b valid=%b required 1 0", bus.in_ready,
                  bus.out_valid);
      end
      send(60'd12345);
      wait_valid(lat);
      checks++;
      if (lat != 10 || bus.out_quotient !== 60'd109 || bus.out_remainder !== 7'd28) begin
         failures++;
         $display("FAIL abort_rerun: lat=%0d q=%0d r=%0d required 10 109 28", lat,
                  bus.out_quotient, bus.out_remainder);
      end
      handshake();
   endtask

   task automatic test_random();
      logic [63:0] raw, d64, eq, er, q64, r64;
      int lat;
      for (int i = 0; i < 2000; i++) begin
         raw = {$urandom(), $urandom()};
         d64 = {4'd0, raw[59:0]};
         eq  = d64 / 64'd113;
         er  = d64 % 64'd113;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(raw[59:0]);
         wait_valid(lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         q64 = {4'd0, bus.out_quotient};
         r64 = {57'd0, bus.out_remainder};
         checks++;
         if (lat != 10 || bus.out_valid !== 1'b1 || q64 !== eq || r64 !== er) begin
            failures++;
            $display("FAIL rand%0d: d=%0d lat=%0d q=%0d r=%0d required q=%0d r=%0d", i, d64, lat,
                     q64, r64, eq, er);
         end
         checks++;
         if (q64 * 64'd113 + r64 !== d64 || r64 >= 64'd113) begin
            failures++;
            $display("FAIL rand%0d_identity: q=%0d r=%0d required q*113+r=%0d, r<113", i, q64,
                     r64, d64);
         end
         handshake();
      end
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_dividend = '0;
      bus.out_ready   = 1'b0;
      @(negedge clk);
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_midbusy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
